// File: rtl/fifo_arb_pkg.sv
// Shared constants, state encoding and sizing helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_BURST = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Burst counter must hold 0..BURST
    function automatic int cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first requester found at (last+1), (last+2), ... mod NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // Scan NREQ slots starting just after the previous owner; the previous
    // owner itself is visited last, so it only wins when nobody else asks.
    always_comb begin
        int p;
        p     = 0;
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            p = (int'(last_i) + k) % NREQ;
            if (!any_o && req_i[p]) begin
                any_o    = 1'b1;
                win_o[p] = 1'b1;
                idx_o    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers,
// granting bounded bursts and honouring the FIFO full / almost-full flags.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DW    = DEF_DW,
    parameter int BURST = DEF_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din_bus,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    input  logic                 fifo_full,
    input  logic                 fifo_full_n,
    output logic                 fifo_we,
    output logic [DW-1:0]        fifo_din,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(BURST);

    logic [0:0]      state_q;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   gidx_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            req_g;
    logic            last_word;
    logic [DW-1:0]   lane [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = din_bus[i*DW +: DW];
    end

    // Write strobe follows the registered owner; reset/clear kill it in-cycle
    always_comb begin
        req_g     = |(req & grant_q);
        fifo_we   = (state_q == GRANT) && req_g && !fifo_full && !rst && !clr;
        ack       = fifo_we ? grant_q : '0;
        fifo_din  = lane[gidx_q];
        last_word = (cnt_q == CW'(BURST - 1));
    end

    assign grant = grant_q;
    assign busy  = (state_q == GRANT);

    // Arbitration FSM, burst counter and owner bookkeeping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any && !fifo_full_n) begin
                        state_q <= GRANT;
                        grant_q <= win;
                        gidx_q  <= win_idx;
                        last_q  <= win_idx;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    // Requester gone, or its final burst word goes out now
                    if (!req_g || (fifo_we && last_word)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        gidx_q  <= '0;
                        cnt_q   <= '0;
                    end else if (fifo_we) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized check of fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic              clk = 1'b0;
    logic              rst, clr;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] din_bus;
    logic [NREQ-1:0]   ack, grant;
    logic              fifo_full, fifo_full_n;
    logic              fifo_we;
    logic [DW-1:0]     fifo_din;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .req         (req),
        .din_bus     (din_bus),
        .ack         (ack),
        .grant       (grant),
        .fifo_full   (fifo_full),
        .fifo_full_n (fifo_full_n),
        .fifo_we     (fifo_we),
        .fifo_din    (fifo_din),
        .busy        (busy)
    );

    int errors = 0;
    int checks = 0;
    int wr_total = 0;

    // model: who owns the port, who owned it last, words written this burst
    bit m_busy;
    int m_owner;
    int m_last;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_cnt   = 0;
    endtask

    task automatic step(input logic r, input logic c, input logic [NREQ-1:0] rq,
                        input logic f, input logic af);
        logic            we_e;
        logic [NREQ-1:0] g_e;
        @(negedge clk);
        rst = r; clr = c; req = rq; fifo_full = f; fifo_full_n = af;
        din_bus = {$urandom, $urandom};
        #1;
        g_e  = m_busy ? (NREQ'(1) << m_owner) : '0;
        we_e = m_busy && rq[m_owner] && !f && !r && !c;
        chk("grant", 32'(grant), 32'(g_e));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("we", 32'(fifo_we), 32'(we_e));
        chk("ack", 32'(ack), we_e ? 32'(g_e) : 32'd0);
        if (we_e) chk("din", 32'(fifo_din), 32'(din_bus[m_owner*DW +: DW]));
        if (fifo_we) wr_total++;
        @(posedge clk);
        if (r || c) begin
            model_reset();
        end else if (!m_busy) begin
            if (rq != '0 && !af) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int p;
                    p = (m_last + k) % NREQ;
                    if (!m_busy && rq[p]) begin
                        m_busy  = 1'b1;
                        m_owner = p;
                        m_last  = p;
                        m_cnt   = 0;
                    end
                end
            end
        end else if (!rq[m_owner]) begin
            m_busy = 1'b0;
        end else if (we_e) begin
            m_cnt++;
            if (m_cnt == BURST) m_busy = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        rst = 1'b1; clr = 1'b0; req = '0; fifo_full = 1'b0; fifo_full_n = 1'b0;
        din_bus = '0;
        repeat (2) @(posedge clk);
        model_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // all requesting, FIFO never full: 5 bursts of 4 with idle gaps
        wr_total = 0;
        repeat (25) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
        chk("thruput", 32'(wr_total), 32'd20);

        // almost-full blocks burst start until it drops
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 4'b0010, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);

        // full stall mid-burst
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);

        // random traffic with sticky requests
        rq = '0;
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 4) == 0) rq[i] = ~rq[i];
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, rq,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
